// File: rtl/data_store_unit_pkg.sv
// Shared types and helpers for the byte-serialising store unit.
// Store-size encodings, FSM state encoding, and the size/alignment decode.
package data_store_unit_pkg;

  localparam logic [1:0] StoreByte = 2'd0;
  localparam logic [1:0] StoreHalf = 2'd1;
  localparam logic [1:0] StoreWord = 2'd2;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWrite = 2'd1,
    StDone  = 2'd2
  } state_e;

  // Index of the final byte of a store (n-1); reserved size maps to 0.
  function automatic logic [1:0] last_byte_idx(input logic [1:0] size);
    logic [1:0] idx;
    case (size)
      StoreByte: idx = 2'd0;
      StoreHalf: idx = 2'd1;
      StoreWord: idx = 2'd3;
      default:   idx = 2'd0;
    endcase
    return idx;
  endfunction

  // True when the request must be dropped: reserved size or natural misalignment.
  function automatic logic store_bad(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      StoreByte: bad = 1'b0;
      StoreHalf: bad = addr_lo[0];
      StoreWord: bad = (addr_lo != 2'b00);
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/data_store_unit_fifo.sv
// Synchronous FIFO used as the store request queue.
// Depth must be a power of two (>= 2); push when full and pop when empty are ignored.
module data_store_unit_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [PtrW:0]    wr_ptr_q, wr_ptr_d;
  logic [PtrW:0]    rd_ptr_q, rd_ptr_d;
  logic [Width-1:0] mem_q [Depth];
  logic             do_push, do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  always_comb begin
    empty_o = (wr_ptr_q == rd_ptr_q);
    full_o  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
              (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
    do_push = push_i && !full_o;
    do_pop  = pop_i && !empty_o;
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    rdata_o  = mem_q[rd_ptr_q[PtrW-1:0]];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q[PtrW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/data_store_unit.sv
// Queues store requests and serialises each into big-endian single-byte writes.
// Byte k of an n-byte store goes to base+k carrying data[8*(n-1-k) +: 8].
module data_store_unit
  import data_store_unit_pkg::*;
#(
  parameter int unsigned AddrSize = 32,
  parameter int unsigned Width    = 32,
  parameter int unsigned Depth    = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                stop_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [AddrSize-1:0] req_addr_i,
  input  logic [Width-1:0]    req_data_i,
  input  logic [1:0]          req_size_i,
  output logic                mem_we_o,
  output logic [AddrSize-1:0] mem_addr_o,
  output logic [7:0]          mem_wdata_o,
  input  logic                mem_ready_i,
  output logic                done_o,
  output logic                err_o,
  output logic                idle_o
);

  localparam int unsigned EntryW = AddrSize + Width + 2;

  logic [EntryW-1:0]   fifo_wdata, fifo_rdata;
  logic                fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [AddrSize-1:0] head_addr;
  logic [Width-1:0]    head_data;
  logic [1:0]          head_size;

  state_e              state_q, state_d;
  logic [AddrSize-1:0] base_q, base_d;
  logic [Width-1:0]    data_q, data_d;
  logic [1:0]          last_q, last_d;
  logic [1:0]          k_q, k_d;
  logic                err_q, err_d;
  logic [1:0]          sel;

  assign fifo_wdata = {req_addr_i, req_data_i, req_size_i};
  assign {head_addr, head_data, head_size} = fifo_rdata;
  assign fifo_push  = req_valid_i && !fifo_full;
  assign req_ready_o = !fifo_full;

  data_store_unit_fifo #(
    .Width (EntryW),
    .Depth (Depth)
  ) u_req_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    data_d   = data_q;
    last_d   = last_q;
    k_d      = k_q;
    err_d    = 1'b0;
    fifo_pop = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty && !stop_i) begin
          fifo_pop = 1'b1;
          if (store_bad(head_size, head_addr[1:0])) begin
            err_d = 1'b1;
          end else begin
            state_d = StWrite;
            base_d  = head_addr;
            data_d  = head_data;
            last_d  = last_byte_idx(head_size);
            k_d     = 2'd0;
          end
        end
      end
      StWrite: begin
        if (mem_ready_i) begin
          if (k_q == last_q) begin
            state_d = StDone;
          end else begin
            k_d = k_q + 2'd1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      base_q  <= '0;
      data_q  <= '0;
      last_q  <= 2'd0;
      k_q     <= 2'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      data_q  <= data_d;
      last_q  <= last_d;
      k_q     <= k_d;
      err_q   <= err_d;
    end
  end

  // Outputs depend only on registered state, so a stall holds them stable.
  always_comb begin
    sel         = last_q - k_q;
    mem_we_o    = (state_q == StWrite);
    mem_addr_o  = mem_we_o ? base_q + AddrSize'(k_q) : '0;
    mem_wdata_o = mem_we_o ? data_q[8*sel +: 8] : 8'h00;
    done_o      = (state_q == StDone);
    err_o       = err_q;
    idle_o      = fifo_empty && (state_q == StIdle);
  end

endmodule

// File: tb/tb_data_store_unit.sv
// Self-checking bench for data_store_unit: a scoreboard of expected byte writes
// is filled when requests are accepted and drained as the DUT writes memory.
module tb_data_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stop = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [31:0] req_data = '0;
  logic [1:0]  req_size = '0;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ready = 1'b1;
  logic        done, err, idle;

  data_store_unit #(
    .AddrSize (32),
    .Width    (32),
    .Depth    (4)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .stop_i      (stop),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_addr_i  (req_addr),
    .req_data_i  (req_data),
    .req_size_i  (req_size),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_ready_i (mem_ready),
    .done_o      (done),
    .err_o       (err),
    .idle_o      (idle)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_fail = 0, cyc = 0;
  logic [31:0] exp_addr[$];
  logic [7:0]  exp_data[$];
  int exp_done = 0, exp_err = 0;
  int wr_cnt = 0, done_cnt = 0, err_cnt = 0;
  int first_wr_cyc = -1, last_wr_cyc = -1, done_cyc = -1;
  bit last_acc = 1'b0, last_idle = 1'b0, prev_stall = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [7:0]  prev_data = '0;

  task automatic monitor();
    logic [31:0] ea;
    logic [7:0]  ed;
    if (prev_stall) begin
      n_cmp++;
      if (mem_we !== 1'b1 || mem_addr !== prev_addr || mem_wdata !== prev_data) begin
        n_fail++;
        $display("FAIL stall_hold: got we=%b addr=%h data=%h, expected we=1 addr=%h data=%h",
                 mem_we, mem_addr, mem_wdata, prev_addr, prev_data);
      end
    end
    prev_stall = (mem_we === 1'b1) && !mem_ready;
    prev_addr  = mem_addr;
    prev_data  = mem_wdata;
    if (mem_we === 1'b1 && mem_ready) begin
      wr_cnt++;
      if (first_wr_cyc < 0) first_wr_cyc = cyc;
      last_wr_cyc = cyc;
      n_cmp++;
      if (exp_addr.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got addr=%h data=%h, expected no write",
                 mem_addr, mem_wdata);
      end else begin
        ea = exp_addr.pop_front();
        ed = exp_data.pop_front();
        if (mem_addr !== ea || mem_wdata !== ed) begin
          n_fail++;
          $display("FAIL byte_write: got addr=%h data=%h, expected addr=%h data=%h",
                   mem_addr, mem_wdata, ea, ed);
        end
      end
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (err === 1'b1) err_cnt++;
    if (done === 1'b1 && err === 1'b1) begin
      n_cmp++;
      n_fail++;
      $display("FAIL done_err_overlap: got done=1 err=1, expected at most one");
    end
    last_acc  = req_valid && (req_ready === 1'b1);
    last_idle = (idle === 1'b1);
  endtask

  task automatic cycle();
    @(negedge clk);
    monitor();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic push_req(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                          output int acc);
    int n;
    bit bad;
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    req_size  = s;
    acc = -1;
    for (int i = 0; i < 100; i++) begin
      cycle();
      if (last_acc) begin
        acc = cyc - 1;
        break;
      end
    end
    req_valid = 1'b0;
    if (acc < 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL push_timeout: got req_ready=0 for 100 cycles, expected accept");
    end else begin
      n   = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
      bad = (s == 2'd3) || (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'b00);
      if (bad) begin
        exp_err++;
      end else begin
        for (int k = 0; k < n; k++) begin
          exp_addr.push_back(a + 32'(k));
          exp_data.push_back(8'(d >> (8 * (n - 1 - k))));
        end
        exp_done++;
      end
    end
  endtask

  task automatic wait_drain(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      cycle();
      if (last_idle && exp_addr.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s_drain: got %0d bytes outstanding idle=%b, expected 0 and idle=1",
               name, exp_addr.size(), idle);
    end
    n_cmp++;
    if (done_cnt != exp_done || err_cnt != exp_err) begin
      n_fail++;
      $display("FAIL %s_pulses: got done=%0d err=%0d, expected done=%0d err=%0d",
               name, done_cnt, err_cnt, exp_done, exp_err);
    end
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if ({mem_we, mem_addr, mem_wdata, done, err, idle, req_ready} !== {1'b0, 32'h0, 8'h0,
        1'b0, 1'b0, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_outputs: got we=%b addr=%h wd=%h done=%b err=%b idle=%b rdy=%b, expected 0 0 0 0 0 1 1",
               mem_we, mem_addr, mem_wdata, done, err, idle, req_ready);
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    cycle();
    n_cmp++;
    if (idle !== 1'b1 || req_ready !== 1'b1 || mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset: got idle=%b rdy=%b we=%b, expected 1 1 0", idle, req_ready, mem_we);
    end
  endtask

  task automatic test_word();
    int acc;
    first_wr_cyc = -1;
    push_req(32'h10, 32'hDEADBEEF, 2'd2, acc);
    wait_drain("word");
    n_cmp++;
    if (first_wr_cyc - acc != 2 || last_wr_cyc - first_wr_cyc != 3 || done_cyc - acc != 6) begin
      n_fail++;
      $display("FAIL word_latency: got first=+%0d span=%0d done=+%0d, expected +2 3 +6",
               first_wr_cyc - acc, last_wr_cyc - first_wr_cyc, done_cyc - acc);
    end
  endtask

  task automatic test_misaligned();
    int acc;
    int w0;
    w0 = wr_cnt;
    push_req(32'h21, 32'h0000BEEF, 2'd1, acc);
    wait_drain("half_odd");
    push_req(32'h32, 32'h11223344, 2'd2, acc);
    wait_drain("word_odd");
    push_req(32'h40, 32'h55667788, 2'd3, acc);
    wait_drain("reserved");
    n_cmp++;
    if (wr_cnt != w0) begin
      n_fail++;
      $display("FAIL dropped_writes: got %0d writes, expected 0", wr_cnt - w0);
    end
    push_req(32'h21, 32'h000000A5, 2'd0, acc);
    wait_drain("byte");
    push_req(32'h22, 32'h0000C3D4, 2'd1, acc);
    wait_drain("half");
  endtask

  task automatic test_queue_fill();
    int acc;
    int w0;
    mem_ready = 1'b0;
    w0 = wr_cnt;
    for (int i = 0; i < 5; i++) begin
      push_req(32'h100 + 32'(4 * i), 32'hA0B0C0D0 + 32'(i), 2'd2, acc);
    end
    n_cmp++;
    if (req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_ready: got req_ready=%b, expected 0", req_ready);
    end
    mem_ready = 1'b1;
    wait_drain("fill");
    n_cmp++;
    if (wr_cnt - w0 != 20) begin
      n_fail++;
      $display("FAIL fill_count: got %0d bytes, expected 20", wr_cnt - w0);
    end
  endtask

  task automatic test_stall();
    int acc;
    int w0;
    w0 = wr_cnt;
    mem_ready = 1'b1;
    push_req(32'h40, 32'h01234567, 2'd2, acc);
    cycle();
    cycle();
    mem_ready = 1'b0;
    cycle();
    cycle();
    mem_ready = 1'b1;
    wait_drain("stall");
    n_cmp++;
    if (wr_cnt - w0 != 4 || done_cyc != last_wr_cyc + 1) begin
      n_fail++;
      $display("FAIL stall_done: got bytes=%0d done_gap=%0d, expected 4 and 1",
               wr_cnt - w0, done_cyc - last_wr_cyc);
    end
  endtask

  task automatic test_wrap_reset();
    int acc;
    int w0;
    int d0;
    push_req(32'hFFFFFFFC, 32'hCAFEF00D, 2'd2, acc);
    wait_drain("wrap");
    mem_ready = 1'b0;
    push_req(32'hFFFFFFFE, 32'h0000BEEF, 2'd1, acc);
    push_req(32'h50, 32'h0000005A, 2'd0, acc);
    n_cmp++;
    if (mem_we !== 1'b1 || mem_addr !== 32'hFFFFFFFE) begin
      n_fail++;
      $display("FAIL pre_reset_write: got we=%b addr=%h, expected we=1 addr=fffffffe",
               mem_we, mem_addr);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (mem_we !== 1'b0 || mem_addr !== 32'h0 || idle !== 1'b1 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset: got we=%b addr=%h idle=%b rdy=%b, expected 0 0 1 1",
               mem_we, mem_addr, idle, req_ready);
    end
    exp_addr.delete();
    exp_data.delete();
    exp_done -= 2;
    prev_stall = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_ready = 1'b1;
    w0 = wr_cnt;
    d0 = done_cnt;
    for (int i = 0; i < 8; i++) cycle();
    n_cmp++;
    if (wr_cnt != w0 || done_cnt != d0 || idle !== 1'b1) begin
      n_fail++;
      $display("FAIL queue_flushed: got writes=%0d dones=%0d idle=%b, expected 0 0 1",
               wr_cnt - w0, done_cnt - d0, idle);
    end
  endtask

  task automatic test_back_to_back_stop();
    int acc;
    int w0;
    stop = 1'b1;
    w0 = wr_cnt;
    push_req(32'h200, 32'h89ABCDEF, 2'd2, acc);
    push_req(32'h204, 32'h76543210, 2'd2, acc);
    for (int i = 0; i < 10; i++) cycle();
    n_cmp++;
    if (wr_cnt != w0 || idle !== 1'b0 || mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_hold: got writes=%0d idle=%b we=%b, expected 0 0 0",
               wr_cnt - w0, idle, mem_we);
    end
    stop = 1'b0;
    first_wr_cyc = -1;
    wait_drain("stop");
    n_cmp++;
    if (done_cyc - first_wr_cyc != 10 || wr_cnt - w0 != 8) begin
      n_fail++;
      $display("FAIL back_to_back: got span=%0d bytes=%0d, expected 10 and 8",
               done_cyc - first_wr_cyc, wr_cnt - w0);
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_misaligned();
    test_queue_fill();
    test_stall();
    test_wrap_reset();
    test_back_to_back_stop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion by 1ms, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
